// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU load/store path.
// Op codes, LSU states and a load/store classifier.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LBU = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LHU = 4'd3,
    LSU_LW  = 4'd4,
    LSU_LWL = 4'd5,
    LSU_LWR = 4'd6,
    LSU_SB  = 4'd7,
    LSU_SH  = 4'd8,
    LSU_SW  = 4'd9
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  // Codes 0..6 are loads; everything else is a store or unmapped.
  function automatic logic is_load(input logic [3:0] op);
    return op <= LSU_LWR;
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store data,
// load extension / LWL-LWR merge and alignment checking.
module mips_cpu_lsu_align
  import mips_cpu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rt_in,
  input  logic [31:0] readdata,
  input  logic [31:0] wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [4:0]  w_sr;
  logic [4:0]  w_sl;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be_b;
  logic [3:0]  w_be_h;

  // s = 8*k for right shifts, 8*(3-k) for LWL
  assign w_sr   = {offset, 3'b000};
  assign w_sl   = {~offset, 3'b000};
  assign w_byte = readdata[w_sr +: 8];
  assign w_half = offset[1] ? readdata[31:16] : readdata[15:0];
  assign w_be_b = 4'b0001 << offset;
  assign w_be_h = offset[1] ? 4'b1100 : 4'b0011;

  // Per-op lane decode; unmapped codes fall out as misaligned
  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'd0;
    load_data  = 32'd0;
    misaligned = 1'b1;
    unique case (1'b1)
      (op == LSU_LB): begin
        byteenable = w_be_b;
        load_data  = {{24{w_byte[7]}}, w_byte};
        misaligned = 1'b0;
      end
      (op == LSU_LBU): begin
        byteenable = w_be_b;
        load_data  = {24'd0, w_byte};
        misaligned = 1'b0;
      end
      (op == LSU_LH): begin
        byteenable = w_be_h;
        load_data  = {{16{w_half[15]}}, w_half};
        misaligned = offset[0];
      end
      (op == LSU_LHU): begin
        byteenable = w_be_h;
        load_data  = {16'd0, w_half};
        misaligned = offset[0];
      end
      (op == LSU_LW): begin
        byteenable = 4'b1111;
        load_data  = readdata;
        misaligned = |offset;
      end
      (op == LSU_LWL): begin
        byteenable = 4'b1111;
        load_data  = (readdata << w_sl)
                   | (rt_in & ((32'd1 << w_sl) - 32'd1));
        misaligned = 1'b0;
      end
      (op == LSU_LWR): begin
        byteenable = 4'b1111;
        load_data  = (readdata >> w_sr)
                   | (rt_in & ~(32'hFFFF_FFFF >> w_sr));
        misaligned = 1'b0;
      end
      (op == LSU_SB): begin
        byteenable = w_be_b;
        writedata  = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      (op == LSU_SH): begin
        byteenable = w_be_h;
        writedata  = {2{wdata[15:0]}};
        misaligned = offset[0];
      end
      (op == LSU_SW): begin
        byteenable = 4'b1111;
        writedata  = wdata;
        misaligned = |offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: IDLE/ACCESS/DONE FSM driving an
// Avalon-style data bus, with optional waitrequest timeout.
module mips_cpu_lsu
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [31:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_rt;
  logic [31:0] r_tmo;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_load;
  logic [31:0] r_addr;
  logic        r_read;
  logic        r_write;
  logic [3:0]  r_be;
  logic [31:0] r_wd;

  logic        w_idle;
  logic [3:0]  w_op;
  logic [1:0]  w_off;
  logic [31:0] w_rt;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ld;
  logic        w_mis;

  // Decode live inputs while idle, the latched request afterwards
  assign w_idle = (r_state == ST_IDLE);
  assign w_op   = w_idle ? op : r_op;
  assign w_off  = w_idle ? addr[1:0] : r_off;
  assign w_rt   = w_idle ? rt_in : r_rt;

  mips_cpu_lsu_align u_align (
    .op         (w_op),
    .offset     (w_off),
    .rt_in      (w_rt),
    .readdata   (readdata),
    .wdata      (wdata),
    .byteenable (w_be),
    .writedata  (w_wd),
    .load_data  (w_ld),
    .misaligned (w_mis)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign load_data  = r_load;
  assign address    = r_addr;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_be;
  assign writedata  = r_wd;

  // Transfer FSM with registered bus and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= 4'd0;
      r_off   <= 2'd0;
      r_rt    <= 32'd0;
      r_tmo   <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_load  <= 32'd0;
      r_addr  <= 32'd0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_be    <= 4'b0000;
      r_wd    <= 32'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req) begin
            if (w_mis) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_load  <= 32'd0;
            end else begin
              r_state <= ST_ACCESS;
              r_busy  <= 1'b1;
              r_op    <= op;
              r_off   <= addr[1:0];
              r_rt    <= rt_in;
              r_tmo   <= 32'd0;
              r_addr  <= {addr[31:2], 2'b00};
              r_be    <= w_be;
              r_wd    <= w_wd;
              r_read  <= is_load(op);
              r_write <= ~is_load(op);
            end
          end
        end
        ST_ACCESS: begin
          if (!waitrequest) begin
            if (r_read) r_load <= w_ld;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (TIMEOUT_CYCLES != 0 && r_tmo == TMO_LAST) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu: loads, stores, stalls,
// misalignment, timeout and mid-transfer reset.
module tb_mips_cpu_lsu;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rt_in = 32'd0;
  logic        busy, done, err, read, write;
  logic [31:0] load_data, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;

  int n_chk = 0;
  int n_err = 0;

  mips_cpu_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .rt_in       (rt_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .load_data   (load_data),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request; slave stalls the first 'waits' strobe cycles
  task automatic xfer(input string tag,
                      input logic [3:0] o,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] rt,
                      input int waits,
                      input logic [31:0] rd,
                      output int lat,
                      output int nstb,
                      output int nbusy,
                      output logic [3:0] be_o,
                      output logic [31:0] wd_o,
                      output logic [31:0] adr_o,
                      output logic wr_o,
                      output logic [31:0] ld_o,
                      output logic e_o);
    nstb = 0; nbusy = 0;
    be_o = 4'hx; wd_o = 'x; adr_o = 'x; wr_o = 1'bx;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = wd; rt_in = rt;
    readdata = rd; waitrequest = (waits > 0);
    @(negedge clk);
    req = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      if (read || write) begin
        if (nstb == 0) begin
          be_o = byteenable; wd_o = writedata;
          adr_o = address; wr_o = write;
        end
        nstb++;
        waitrequest = (nstb <= waits);
      end
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk({tag, "_done_seen"}, 32'd0, 32'd1);
    ld_o = load_data;
    e_o = err;
    waitrequest = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got hang exp finish");
    $fatal(1);
  end

  initial begin
    int lat, ns, nb;
    logic [3:0] be;
    logic [31:0] wdo, adr, ld;
    logic wr, e, saw_done;

    @(negedge clk);
    chk("rst_ctl", {27'd0, busy, done, err, read, write}, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_adr", address, 32'd0);
    chk("rst_wd", writedata, 32'd0);
    reset = 1'b0;

    xfer("sw", LSU_SW, 32'h1000, 32'hDEADBEEF, 0, 0, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("sw_adr", adr, 32'h1000);
    chk("sw_wr", {31'd0, wr}, 32'd1);
    chk("sw_stb", ns, 1);
    chk("sw_be", {28'd0, be}, 32'hF);
    chk("sw_wd", wdo, 32'hDEADBEEF);
    chk("sw_lat", lat, 3);
    chk("sw_err", {31'd0, e}, 32'd0);

    xfer("sb", LSU_SB, 32'h1003, 32'h000000A5, 0, 0, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("sb_be", {28'd0, be}, 32'h8);
    chk("sb_wd", wdo, 32'hA5A5A5A5);
    chk("sb_adr", adr, 32'h1000);

    xfer("lb", LSU_LB, 32'h1003, 0, 0, 0, 32'hA5000000,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lb_be", {28'd0, be}, 32'h8);
    chk("lb_rd", {31'd0, wr}, 32'd0);
    chk("lb_ld", ld, 32'hFFFFFFA5);

    xfer("lbu", LSU_LBU, 32'h1003, 0, 0, 0, 32'hA5000000,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lbu_ld", ld, 32'h000000A5);

    xfer("lh", LSU_LH, 32'h2002, 0, 0, 4, 32'h80017FFF,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lh_stb", ns, 5);
    chk("lh_busy", nb, 5);
    chk("lh_be", {28'd0, be}, 32'hC);
    chk("lh_ld", ld, 32'hFFFF8001);
    chk("lh_lat", lat, 7);

    xfer("lhu", LSU_LHU, 32'h2000, 0, 0, 0, 32'h80017FFF,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lhu_be", {28'd0, be}, 32'h3);
    chk("lhu_ld", ld, 32'h00007FFF);

    xfer("sh", LSU_SH, 32'h2002, 32'hFFFF1234, 0, 1, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wd", wdo, 32'h12341234);
    chk("sh_stb", ns, 2);

    xfer("lwl", LSU_LWL, 32'h3001, 0, 32'h11223344, 0, 32'hAABBCCDD,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lwl_be", {28'd0, be}, 32'hF);
    chk("lwl_ld", ld, 32'hCCDD3344);

    xfer("lwr", LSU_LWR, 32'h3001, 0, 32'h11223344, 0, 32'hAABBCCDD,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lwr_ld", ld, 32'h11AABBCC);

    xfer("lwl3", LSU_LWL, 32'h3003, 0, 32'h11223344, 0, 32'hAABBCCDD,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lwl3_ld", ld, 32'hAABBCCDD);

    xfer("lw", LSU_LW, 32'h4000, 0, 0, 0, 32'h0BADF00D,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lw_ld", ld, 32'h0BADF00D);

    xfer("lwmis", LSU_LW, 32'h4002, 0, 0, 0, 32'h12345678,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("lwmis_stb", ns, 0);
    chk("lwmis_busy", nb, 0);
    chk("lwmis_lat", lat, 2);
    chk("lwmis_err", {31'd0, e}, 32'd1);
    chk("lwmis_ld", ld, 32'd0);

    xfer("shmis", LSU_SH, 32'h4001, 0, 0, 0, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("shmis_err", {31'd0, e}, 32'd1);
    chk("shmis_stb", ns, 0);

    xfer("badop", 4'hF, 32'h5000, 0, 0, 0, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("badop_err", {31'd0, e}, 32'd1);
    chk("badop_stb", ns, 0);

    xfer("tmo", LSU_LW, 32'h6000, 0, 0, 1000, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("tmo_stb", ns, 8);
    chk("tmo_err", {31'd0, e}, 32'd1);
    chk("tmo_lat", lat, 10);

    @(negedge clk);
    req = 1'b1; op = LSU_LW; addr = 32'h7000;
    waitrequest = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("mid_read", {31'd0, read}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst", {29'd0, read, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("mid_nodone", {31'd0, saw_done}, 32'd0);

    xfer("post", LSU_SW, 32'h7004, 32'hCAFEF00D, 0, 0, 0,
         lat, ns, nb, be, wdo, adr, wr, ld, e);
    chk("post_adr", adr, 32'h7004);
    chk("post_wd", wdo, 32'hCAFEF00D);
    chk("post_lat", lat, 3);
    chk("post_err", {31'd0, e}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
Load/store unit that consumes the ALU's effective address (ALUOut) and performs the memory access on the data-side Avalon-style bus. It covers every MIPS load and store flavour: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH and SW. It does byte-lane steering, byte-enable generation, sign/zero extension and LWL/LWR merging. It holds the CPU via busy until the bus transfer completes.

Parameters:
TIMEOUT_CYCLES, 0, max consecutive waitrequest cycles before abort with err; 0 = never time out.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  start access; sampled only in IDLE
op  in  4  lsu_op_t from mips_cpu_pkg
addr  in  32  effective byte address (ALUOut)
wdata  in  32  store source (rt)
rt_in  in  32  current rt value, merge source for LWL/LWR
busy  out  1  high from the cycle after acceptance until the cycle before done
done  out  1  one-cycle completion pulse
err  out  1  valid with done; misaligned address or timeout
load_data  out  32  result for rt; valid with done and held until the next acceptance
address  out  32  word-aligned bus address, {addr[31:2],2'b00}
read  out  1  bus read strobe
write  out  1  bus write strobe
byteenable  out  4  active byte lanes
writedata  out  32  lane-steered store data
waitrequest  in  1  slave stall
readdata  in  32  bus read data; valid in the cycle read=1 and waitrequest=0

Behaviour:
- Reset (async, immediate): state=IDLE. busy, done, err, read and write are 0. load_data, address, writedata and the timeout counter are 0. byteenable=4'b0000.
- Reset mid-transfer drops read/write in the same instant; no completion is reported.
- Byte order is little-endian: byte offset k=addr[1:0] maps to lane k, bits 8k+7:8k.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, req=1:
  - Misaligned access (LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0): go to DONE with err=1 and load_data=0. No bus cycle is issued.
  - Otherwise: latch op, addr and data, drive the bus, go to ACCESS.
- IDLE, req=0: stay in IDLE.
- ACCESS:
  - read or write is held, with address, byteenable and writedata stable, while waitrequest=1.
  - On the first cycle with waitrequest=0: for loads, capture readdata; drop the strobes; go to DONE.
  - Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES while still waitrequest=1, drop the strobes, err=1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. req asserted in DONE is ignored; the CPU re-presents it in IDLE.
- Minimum latency is 3 cycles from acceptance to done (accept -> ACCESS with zero wait -> DONE). Each waitrequest cycle adds 1.
- Stores:
  - SB: writedata={4{wdata[7:0]}}, byteenable=1<<k.
  - SH: writedata={2{wdata[15:0]}}, byteenable=4'b0011 (k=0) or 4'b1100 (k=2).
  - SW: writedata=wdata, byteenable=4'b1111.
- Loads:
  - LB/LBU: byteenable=1<<k. Take lane k, then sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: byteenable per halfword as for SH. Take the selected halfword, then sign-extend or zero-extend.
  - LW: byteenable=4'b1111, load_data=readdata.
  - LWL, with s=8*(3-k): byteenable=4'b1111. load_data=(readdata<<s) | (rt_in & ((1<<s)-1)).
  - LWR, with s=8*k: byteenable=4'b1111. load_data=(readdata>>s) | (rt_in & ~(32'hFFFFFFFF>>s)).
- Unmapped op code: treated as misaligned (err=1, no bus cycle).

Decomposition:
- mips_cpu_pkg holds:
  - lsu_op_t enum: LSU_LB=0, LSU_LBU=1, LSU_LH=2, LSU_LHU=3, LSU_LW=4, LSU_LWL=5, LSU_LWR=6, LSU_SB=7, LSU_SH=8, LSU_SW=9.
  - lsu_state_t enum.
- One combinational sub-module, mips_cpu_lsu_align:
  - Inputs: op, offset, rt_in, readdata, wdata.
  - Outputs: byteenable, writedata, load_data and a misaligned flag.
  - The FSM in mips_cpu_lsu instantiates it.

Test Plan:
- SW, addr=0x1000, wdata=0xDEADBEEF, waitrequest=0 -> address=0x1000, write=1 for 1 cycle, byteenable=1111, done 3 cycles after req, err=0.
- SB, addr=0x1003, wdata=0x000000A5 -> byteenable=1000, writedata=0xA5A5A5A5. LB at the same address with readdata=0xA5000000 -> load_data=0xFFFFFFA5. LBU -> 0x000000A5.
- LH, addr=0x2002, readdata=0x80017FFF, waitrequest high 4 cycles -> read held 5 cycles, byteenable=1100, load_data=0xFFFF8001, done at cycle 7.
- LWL, addr=0x3001, rt_in=0x11223344, readdata=0xAABBCCDD -> load_data=0xCCDD3344. LWR, addr=0x3001 -> load_data=0x11AABBCC.
- LW, addr=0x4002 -> no read strobe, done+err next cycle, load_data=0. With TIMEOUT_CYCLES=8 and waitrequest stuck high -> read dropped, err=1 after 8 stall cycles.
- Assert reset while in ACCESS with waitrequest=1 -> read=0 and busy=0 immediately, no done pulse. A new req after release completes normally.
